imm_ext_arbiter: RTL and testbench

IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

---
 rtl/imm_ext_arbiter_pkg.sv | 15 +
 rtl/imm_ext_arbiter_if.sv | 40 ++++
 rtl/imm_ext_arbiter_imm_gen.sv | 22 ++
 rtl/imm_ext_arbiter.sv | 71 +++++++
 tb/tb_imm_ext_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_ext_arbiter_pkg.sv
// Shared core definitions for the immediate-extension arbiter: immediate
// format encodings and datapath widths.
package imm_ext_arbiter_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_U = 2'b11
  } immsrc_e;

  localparam int INSTR_W = 25;   // instruction bits [31:7]
  localparam int IMM_W   = 32;

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Two request lanes and one result channel of the immediate arbiter.
// slave is the arbiter side, master is the requester/consumer side.
interface imm_ext_arbiter_if #(parameter int TAG_W = 4);
  import imm_ext_arbiter_pkg::*;

  logic               lane0_valid;
  logic               lane0_ready;
  logic [INSTR_W-1:0] lane0_instr;
  logic [1:0]         lane0_immsrc;
  logic [TAG_W-1:0]   lane0_tag;

  logic               lane1_valid;
  logic               lane1_ready;
  logic [INSTR_W-1:0] lane1_instr;
  logic [1:0]         lane1_immsrc;
  logic [TAG_W-1:0]   lane1_tag;

  logic               out_valid;
  logic               out_ready;
  logic [IMM_W-1:0]   out_imm;
  logic               out_lane;
  logic [TAG_W-1:0]   out_tag;

  modport slave (
    input  lane0_valid, lane0_instr, lane0_immsrc, lane0_tag,
    input  lane1_valid, lane1_instr, lane1_immsrc, lane1_tag,
    input  out_ready,
    output lane0_ready, lane1_ready,
    output out_valid, out_imm, out_lane, out_tag
  );

  modport master (
    output lane0_valid, lane0_instr, lane0_immsrc, lane0_tag,
    output lane1_valid, lane1_instr, lane1_immsrc, lane1_tag,
    output out_ready,
    input  lane0_ready, lane1_ready,
    input  out_valid, out_imm, out_lane, out_tag
  );

endinterface

// File: rtl/imm_ext_arbiter_imm_gen.sv
// Combinational RISC-V immediate extender; instr holds instruction bits [31:7],
// so instr[k] is instruction bit k+7.
module imm_gen
  import imm_ext_arbiter_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic [1:0]         immsrc,
  output logic [IMM_W-1:0]   imm
);

  always_comb begin
    imm = '0;
    case (immsrc_e'(immsrc))
      IMM_I:   imm = {{20{instr[24]}}, instr[24:13]};
      IMM_S:   imm = {{20{instr[24]}}, instr[24:18], instr[4:0]};
      IMM_B:   imm = {{20{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_U:   imm = {instr[24:5], 12'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Two-lane round-robin arbiter in front of a single shared immediate
// generator, with a one-entry registered result stage.
module imm_ext_arbiter
  import imm_ext_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              reset,
  imm_ext_arbiter_if.slave bus
);

  logic               can_accept;
  logic               gnt0;
  logic               gnt1;
  logic               xfer;
  logic               rr_ptr;
  logic [INSTR_W-1:0] sel_instr;
  logic [1:0]         sel_immsrc;
  logic [TAG_W-1:0]   sel_tag;
  logic [IMM_W-1:0]   imm;

  logic               out_valid_q;
  logic [IMM_W-1:0]   out_imm_q;
  logic               out_lane_q;
  logic [TAG_W-1:0]   out_tag_q;

  // rr_ptr only breaks ties; a lone requester always wins.
  assign gnt1       = bus.lane1_valid & (~bus.lane0_valid | rr_ptr);
  assign gnt0       = bus.lane0_valid & ~gnt1;
  assign can_accept = (~out_valid_q | bus.out_ready) & ~reset;
  assign xfer       = can_accept & (gnt0 | gnt1);

  assign bus.lane0_ready = can_accept & gnt0;
  assign bus.lane1_ready = can_accept & gnt1;

  // Mux ahead of the generator so one imm_gen serves both lanes.
  assign sel_instr  = gnt1 ? bus.lane1_instr  : bus.lane0_instr;
  assign sel_immsrc = gnt1 ? bus.lane1_immsrc : bus.lane0_immsrc;
  assign sel_tag    = gnt1 ? bus.lane1_tag    : bus.lane0_tag;

  imm_gen u_imm_gen (
    .instr  (sel_instr),
    .immsrc (sel_immsrc),
    .imm    (imm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_lane_q  <= 1'b0;
      out_tag_q   <= '0;
      rr_ptr      <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_imm_q   <= imm;
      out_lane_q  <= gnt1;
      out_tag_q   <= sel_tag;
      rr_ptr      <= ~gnt1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_lane  = out_lane_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench for imm_ext_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_imm_ext_arbiter;
  import imm_ext_arbiter_pkg::*;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imm_ext_arbiter_if #(.TAG_W(TAG_W)) bus ();

  imm_ext_arbiter #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [31:0]      imm;
    logic             lane;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t sb[$];
  int total = 0;
  int bad   = 0;

  bit               n_v[2];
  logic [24:0]      n_i[2];
  logic [1:0]       n_s[2];
  logic [TAG_W-1:0] n_t[2];
  bit               n_or, n_rst, auto_gen;
  int               pv, pr;
  bit               busy[2];

  bit               m_full, m_rr;
  bit               p_hold;
  logic [31:0]      p_imm;
  logic             p_lane;
  logic [TAG_W-1:0] p_tag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Immediate rebuilt from the full 32-bit instruction word with shifts/masks.
  function automatic logic [31:0] ref_imm(input logic [24:0] f, input logic [1:0] src);
    logic [31:0]        i;
    logic signed [31:0] s;
    logic [31:0]        hi20, hi25, hi31;
    i    = {f, 7'b0};
    s    = i;
    hi20 = s >>> 20;
    hi25 = s >>> 25;
    hi31 = s >>> 31;
    case (src)
      2'd0:    return hi20;
      2'd1:    return (hi25 << 5) | ((i >> 7) & 32'h1F);
      2'd2:    return (hi31 << 12) | (((i >> 7) & 32'h1) << 11)
                      | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
      default: return i & 32'hFFFF_F000;
    endcase
  endfunction

  task automatic tick();
    bit   g, any, can, r0e, r1e;
    res_t r;
    @(negedge clk);
    if (auto_gen) begin
      for (int n = 0; n < 2; n++) begin
        if (!busy[n]) begin
          n_v[n] = ($urandom_range(99) < pv);
          n_i[n] = 25'($urandom);
          n_s[n] = 2'($urandom_range(3));
          n_t[n] = TAG_W'($urandom);
        end
      end
      n_or = ($urandom_range(99) < pr);
    end
    reset            = n_rst;
    bus.out_ready    = n_or;
    bus.lane0_valid  = n_v[0];
    bus.lane0_instr  = n_i[0];
    bus.lane0_immsrc = n_s[0];
    bus.lane0_tag    = n_t[0];
    bus.lane1_valid  = n_v[1];
    bus.lane1_instr  = n_i[1];
    bus.lane1_immsrc = n_s[1];
    bus.lane1_tag    = n_t[1];
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_full));
    if (p_hold) begin
      chk("hold_imm", bus.out_imm, p_imm);
      chk("hold_lane", 32'(bus.out_lane), 32'(p_lane));
      chk("hold_tag", 32'(bus.out_tag), 32'(p_tag));
    end
    can = (!m_full || n_or) && !n_rst;
    any = n_v[0] || n_v[1];
    g   = (n_v[0] && n_v[1]) ? m_rr : n_v[1];
    r0e = can && any && !g;
    r1e = can && any && g;
    chk("lane0_ready", 32'(bus.lane0_ready), 32'(r0e));
    chk("lane1_ready", 32'(bus.lane1_ready), 32'(r1e));
    p_hold  = bus.out_valid && !n_or && !n_rst;
    p_imm   = bus.out_imm;
    p_lane  = bus.out_lane;
    p_tag   = bus.out_tag;
    busy[0] = n_v[0] && !r0e;
    busy[1] = n_v[1] && !r1e;
    if (n_rst) begin
      m_full = 1'b0;
      m_rr   = 1'b0;
      sb.delete();
    end else if (r0e || r1e) begin
      r.imm  = ref_imm(n_i[g], n_s[g]);
      r.lane = g;
      r.tag  = n_t[g];
      sb.push_back(r);
      m_full = 1'b1;
      m_rr   = !g;
    end else if (n_or) begin
      m_full = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got result %0h with nothing expected", bus.out_imm);
        end else begin
          e = sb.pop_front();
          chk("res_imm", bus.out_imm, e.imm);
          chk("res_lane", 32'(bus.out_lane), 32'(e.lane));
          chk("res_tag", 32'(bus.out_tag), 32'(e.tag));
        end
      end
    end
  end

  // Requesters must keep a pending request stable until it is accepted.
  logic [1+25+2+TAG_W-1:0] h_req[2];
  logic                    h_rdy[2];
  initial begin
    h_req[0] = '0; h_req[1] = '0;
    h_rdy[0] = 1'b0; h_rdy[1] = 1'b0;
  end
  always @(posedge clk) begin
    if (h_req[0][1+25+2+TAG_W-1] && !h_rdy[0])
      assert (h_req[0] == {bus.lane0_valid, bus.lane0_instr, bus.lane0_immsrc, bus.lane0_tag})
        else $error("lane0 request changed before ready");
    if (h_req[1][1+25+2+TAG_W-1] && !h_rdy[1])
      assert (h_req[1] == {bus.lane1_valid, bus.lane1_instr, bus.lane1_immsrc, bus.lane1_tag})
        else $error("lane1 request changed before ready");
    h_req[0] <= {bus.lane0_valid, bus.lane0_instr, bus.lane0_immsrc, bus.lane0_tag};
    h_req[1] <= {bus.lane1_valid, bus.lane1_instr, bus.lane1_immsrc, bus.lane1_tag};
    h_rdy[0] <= bus.lane0_ready;
    h_rdy[1] <= bus.lane1_ready;
  end

  initial begin
    logic [31:0] w;
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.lane0_valid = 1'b0; bus.lane0_instr = '0; bus.lane0_immsrc = '0; bus.lane0_tag = '0;
    bus.lane1_valid = 1'b0; bus.lane1_instr = '0; bus.lane1_immsrc = '0; bus.lane1_tag = '0;
    for (int n = 0; n < 2; n++) begin
      n_v[n] = 1'b0; n_i[n] = '0; n_s[n] = '0; n_t[n] = '0; busy[n] = 1'b0;
    end
    auto_gen = 1'b0; n_rst = 1'b1; n_or = 1'b0; pv = 0; pr = 0;
    m_full = 1'b0; m_rr = 1'b0; p_hold = 1'b0;

    tick(); tick();
    n_rst = 1'b0;
    tick();
    chk("rst_imm", bus.out_imm, 32'h0);
    chk("rst_lane", 32'(bus.out_lane), 32'h0);
    chk("rst_tag", 32'(bus.out_tag), 32'h0);

    // Lane 0 alone, I-type
    w = 32'hFFF0_0093;
    n_v[0] = 1'b1; n_i[0] = w[31:7]; n_s[0] = 2'b00; n_t[0] = 4'h5; n_or = 1'b1;
    tick();
    n_v[0] = 1'b0;
    tick();
    chk("dir_i_valid", 32'(bus.out_valid), 32'h1);
    chk("dir_i_imm", bus.out_imm, 32'hFFFF_FFFF);
    chk("dir_i_lane", 32'(bus.out_lane), 32'h0);

    // Lane 1 alone, B-type
    w = 32'hFE00_0EE3;
    n_v[1] = 1'b1; n_i[1] = w[31:7]; n_s[1] = 2'b10; n_t[1] = 4'h9;
    tick();
    n_v[1] = 1'b0;
    tick();
    chk("dir_b_imm", bus.out_imm, 32'hFFFF_FFFC);
    chk("dir_b_lane", 32'(bus.out_lane), 32'h1);

    // Lane 0 alone, U-type
    w = 32'h1234_50B7;
    n_v[0] = 1'b1; n_i[0] = w[31:7]; n_s[0] = 2'b11; n_t[0] = 4'hA;
    tick();
    n_v[0] = 1'b0;
    tick();
    chk("dir_u_imm", bus.out_imm, 32'h1234_5000);
    chk("dir_u_lane", 32'(bus.out_lane), 32'h0);

    // Continuous contention after reset alternates 0,1,0,1
    n_rst = 1'b1; tick(); n_rst = 1'b0;
    auto_gen = 1'b1; pv = 100; pr = 100;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("alt_grant", 32'(bus.lane1_ready), 32'(k % 2));
    end

    // Back-pressure: outputs hold, readies low, then same-cycle transfer
    pr = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_ready", 32'(bus.lane0_ready | bus.lane1_ready), 32'h0);
    end
    pr = 100;
    tick();
    chk("bp_release", 32'(bus.lane0_ready | bus.lane1_ready), 32'h1);

    // Reset with a held result and both lanes pending
    pr = 0;
    tick();
    auto_gen = 1'b0; n_or = 1'b0; n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    tick();
    chk("rst_mid_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_first_grant", 32'(bus.lane0_ready), 32'h1);

    // Randomized traffic under varying load and back-pressure
    auto_gen = 1'b1;
    pv = 50; pr = 50;  repeat (300) tick();
    pv = 90; pr = 30;  repeat (300) tick();
    pv = 30; pr = 90;  repeat (300) tick();
    pv = 100; pr = 100; repeat (200) tick();

    pv = 0; pr = 100;
    repeat (10) tick();
    #5;
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
